// File: rtl/pwm_freq_ctrl_pkg.sv
// Shared types and helpers for the PWM period/duty sequencer.
package pwm_freq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WAIT = 2'd2
  } ctrl_state_t;

  localparam int unsigned DUTY_BITS = 8;

  // Number of bits needed to represent value (at least 1).
  function automatic int unsigned clogb2(input longint unsigned value);
    int unsigned bits;
    bits = 1;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/pwm_freq_ctrl_thr_calc.sv
// Registered duty threshold: (modulus * duty) >> 8, product kept full width before truncation.
module pwm_thr_calc
  import pwm_freq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [DUTY_BITS-1:0] duty,
  output logic [WIDTH-1:0]     thr
);

  logic [WIDTH+DUTY_BITS-1:0] product;

  assign product = {{DUTY_BITS{1'b0}}, modulus} * {{WIDTH{1'b0}}, duty};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr <= '0;
    end else if (en) begin
      thr <= product[WIDTH+DUTY_BITS-1:DUTY_BITS];
    end
  end

endmodule

// File: rtl/pwm_freq_ctrl.sv
// Applies modulus/duty requests to the period counter only at wrap edges, optionally
// stepping the modulus toward the target by RAMP_STEP once per period.
module pwm_freq_ctrl
  import pwm_freq_ctrl_pkg::*;
#(
  parameter int unsigned SYSCLK_FRQ = 50000000,
  parameter int unsigned freq_min   = 1,
  parameter int unsigned nbits_cont = clogb2(longint'(SYSCLK_FRQ / (2 * freq_min)) - 1),
  parameter int unsigned MOD_RST    = 25000,
  parameter int unsigned MOD_MIN    = 2,
  parameter int unsigned RAMP_STEP  = 1000
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [nbits_cont-1:0] iCOUNT,
  input  logic [nbits_cont-1:0] iMOD_REQ,
  input  logic [DUTY_BITS-1:0]  iDUTY_REQ,
  input  logic                  iLOAD,
  input  logic                  iRAMP_EN,
  output logic [nbits_cont-1:0] oMODULE,
  output logic [nbits_cont-1:0] oDUTY_THR,
  output logic                  oBUSY,
  output logic                  oUPD,
  output logic                  oRAMP_DONE
);

  localparam logic [nbits_cont-1:0] MOD_RST_V = nbits_cont'(MOD_RST);
  localparam logic [nbits_cont-1:0] MOD_MIN_V = nbits_cont'(MOD_MIN);
  localparam logic [nbits_cont-1:0] STEP_V    = nbits_cont'(RAMP_STEP);
  localparam logic [nbits_cont-1:0] MOD_ONE   = nbits_cont'(1);

  ctrl_state_t           state;
  logic [nbits_cont-1:0] tgt_mod;
  logic [DUTY_BITS-1:0]  tgt_duty;
  logic                  ramp;
  logic [nbits_cont-1:0] nxt_mod;
  logic [nbits_cont-1:0] nxt_thr;
  logic [nbits_cont-1:0] req_clamped;
  logic [nbits_cont-1:0] step_mod;
  logic [nbits_cont-1:0] calc_mod;
  logic [nbits_cont-1:0] diff;
  logic                  wrap;

  assign req_clamped = (iMOD_REQ < MOD_MIN_V) ? MOD_MIN_V : iMOD_REQ;
  assign wrap        = (iCOUNT == oMODULE - MOD_ONE) || (iCOUNT >= oMODULE);

  // Step never overshoots: once within one step of the target, land on it exactly.
  always_comb begin
    diff     = '0;
    step_mod = oMODULE;
    if (tgt_mod >= oMODULE) begin
      diff     = tgt_mod - oMODULE;
      step_mod = (diff <= STEP_V) ? tgt_mod : oMODULE + STEP_V;
    end else begin
      diff     = oMODULE - tgt_mod;
      step_mod = (diff <= STEP_V) ? tgt_mod : oMODULE - STEP_V;
    end
    calc_mod = ramp ? step_mod : tgt_mod;
  end

  // Threshold is registered on the CALC edge alongside nxt_mod, so both are valid in WAIT.
  pwm_thr_calc #(
    .WIDTH (nbits_cont)
  ) u_thr_calc (
    .clk     (iCLK),
    .rst     (iRST),
    .en      (state == CALC),
    .modulus (calc_mod),
    .duty    (tgt_duty),
    .thr     (nxt_thr)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      oMODULE    <= MOD_RST_V;
      oDUTY_THR  <= MOD_RST_V >> 1;
      oBUSY      <= 1'b0;
      oUPD       <= 1'b0;
      oRAMP_DONE <= 1'b0;
      tgt_mod    <= MOD_RST_V;
      tgt_duty   <= 8'd128;
      ramp       <= 1'b0;
      nxt_mod    <= MOD_RST_V;
    end else begin
      oUPD       <= 1'b0;
      oRAMP_DONE <= 1'b0;
      if (iLOAD) begin
        tgt_mod  <= req_clamped;
        tgt_duty <= iDUTY_REQ;
        ramp     <= iRAMP_EN;
      end
      case (state)
        IDLE: begin
          if (iLOAD) begin
            state <= CALC;
            oBUSY <= 1'b1;
          end
        end
        CALC: begin
          oBUSY <= 1'b1;
          if (!iLOAD) begin
            nxt_mod <= calc_mod;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // A pending update still lands on a wrap that coincides with a new load.
          if (wrap) begin
            oMODULE   <= nxt_mod;
            oDUTY_THR <= nxt_thr;
            oUPD      <= 1'b1;
          end
          if (iLOAD) begin
            state <= CALC;
          end else if (wrap) begin
            if (nxt_mod == tgt_mod) begin
              state      <= IDLE;
              oBUSY      <= 1'b0;
              oRAMP_DONE <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
